invk2j_stream_ctrl: RTL and testbench
=====================================

// Module: invk2j_stream_ctrl
// PURPOSE
//  Upstream feeder/capture stage for the invk2j inverse-kinematics core.
//  - Accepts (x,y) coordinate pairs over a valid/ready stream and drives them onto the core inputs.
//  - Holds the core inputs stable for SETTLE cycles, then samples the core outputs (theta1, theta2).
//  - Buffers results in a small FIFO for a valid/ready consumer.
//  - Replaces the fixed-delay drive/sample loop with a handshaked, back-pressured datapath.
// PARAMETERS
//  DW          32  width of each coordinate and each joint angle
//  SETTLE      8   cycles the core inputs are held before sampling its outputs (>=1)
//  FIFO_DEPTH  4   result FIFO entries (power of 2, >=2)
//  CNT_W       32  width of the completed-result counter
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  s_valid    in   1     input pair valid
//  s_ready    out  1     ctrl can accept a pair
//  s_x        in   DW    x coordinate (to core in0)
//  s_y        in   DW    y coordinate (to core in1)
//  core_in0   out  DW    registered drive to invk2j in0
//  core_in1   out  DW    registered drive to invk2j in1
//  core_out0  in   DW    invk2j out0 (theta1)
//  core_out1  in   DW    invk2j out1 (theta2)
//  m_valid    out  1     result available (FIFO not empty)
//  m_ready    in   1     consumer takes result
//  m_data     out  2*DW  {theta1,theta2} at FIFO head
//  busy       out  1     state != IDLE
//  res_count  out  CNT_W results pushed since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: state=IDLE; core_in0/1=0; FIFO empty; m_valid=0; res_count=0; busy=0.
//    s_ready=0 while rst=1. Reset mid-transaction aborts it and flushes the FIFO.
//  - FSM IDLE -> WAIT -> CAPT -> IDLE.
//    - IDLE: s_ready = (fifo_level < FIFO_DEPTH).
//      On s_valid&&s_ready: core_in0<=s_x, core_in1<=s_y, cnt<=SETTLE-1, go WAIT.
//    - WAIT: if cnt==0 go CAPT, else cnt<=cnt-1. WAIT lasts exactly SETTLE cycles.
//    - CAPT: push {core_out0,core_out1}; res_count++; go IDLE. s_ready=0 in WAIT and CAPT.
//  - Latency: accept edge E0 -> core_in valid after E0 -> push at edge E0+SETTLE+1.
//    m_valid (if FIFO was empty) visible the cycle after that edge.
//    Throughput is one pair per SETTLE+2 cycles.
//  - core_in0/1 hold their last value after capture; they are not cleared.
//  - Admission guarantee: one pair in flight and accept only if a slot is free, so a CAPT push never overflows.
//  - FIFO:
//    - m_data is first-word fall-through from head.
//    - Pop on m_valid&&m_ready.
//    - m_data stays stable while m_valid&&!m_ready.
//    - Simultaneous push and pop: level unchanged, order preserved.
//    - Pointers wrap modulo FIFO_DEPTH.
//    - Full: s_ready=0 in IDLE until a pop.
//  - Arithmetic: data passes through unmodified, no sign handling. res_count wraps silently.
// STRUCTURE
//  - invk2j_pkg: DW default, state encoding (IDLE=0, WAIT=1, CAPT=2), result width 2*DW.
//  - One sub-module, invk2j_res_fifo: parameterised sync FIFO (clk, rst, push, din, pop, dout, level).
//  - The FSM, settle counter and input registers live in this module.
// TESTING (bench uses a stub core: out0=in0+1, out1=in1^32'hFFFF_FFFF)
//  1. Reset: rst=1 for 3 cycles, then release -> all outputs 0; s_ready=1 in the first IDLE cycle.
//  2. Single pair, SETTLE=8: x=32'h0001_0000, y=32'h0002_0000 accepted at E0.
//     -> core_in0/1 hold x/y after E0.
//     -> m_valid rises after E0+9, m_data={32'h0001_0001, 32'hFFFD_FFFF}, res_count=1.
//  3. Backpressure, FIFO_DEPTH=4, m_ready=0: send 4 pairs -> s_ready stays 0 with the 5th offered.
//     Raise m_ready -> 4 results in order; the 5th is accepted once one slot frees.
//  4. Simultaneous push/pop: level=1, m_ready=1 during the CAPT edge -> level stays 1, next result at head.
//  5. rst asserted mid-WAIT with 2 results buffered -> next cycle m_valid=0, busy=0, res_count=0, core_in=0.
//  6. Wrap, CNT_W=4: 17 results -> res_count=1; FIFO pointers wrapped with no loss or reordering.

Source files
------------

// File: rtl/invk2j_pkg.sv
// Shared types for the invk2j stream controller: state encoding and result width.
package invk2j_pkg;

    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    function automatic int res_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/invk2j_res_fifo.sv
// Sync FWFT result FIFO; head visible the cycle after push into an empty FIFO.
// Backpressure: push ignored when full, pop ignored when empty; head holds until popped.
module invk2j_res_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign do_push = push && (level_q != LW'(DEPTH));
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/invk2j_stream_ctrl.sv
// Drives one (x,y) pair into the invk2j core, holds it SETTLE cycles, captures the angles.
// Latency accept->push SETTLE+1 edges; s_ready only in IDLE with a free FIFO slot.
module invk2j_stream_ctrl
    import invk2j_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int SETTLE     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_x,
    input  logic [DW-1:0]         s_y,
    output logic [DW-1:0]         core_in0,
    output logic [DW-1:0]         core_in1,
    input  logic [DW-1:0]         core_out0,
    input  logic [DW-1:0]         core_out1,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DW-1:0]       m_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      res_count
);

    localparam int RW = res_w(DW);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    in0_q, in0_d;
    logic [DW-1:0]    in1_q, in1_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    logic [LW-1:0]    fifo_level;
    logic [RW-1:0]    fifo_dout;
    logic             slot_free;
    logic             push;
    logic             pop;

    // Only one pair is ever in flight, so a free slot at admission guarantees room at capture.
    assign slot_free = fifo_level < LW'(FIFO_DEPTH);
    assign s_ready   = !rst && (state_q == ST_IDLE) && slot_free;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        res_cnt_d = res_cnt_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready) begin
                    in0_d   = s_x;
                    in1_d   = s_y;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CAPT: begin
                push      = 1'b1;
                res_cnt_d = res_cnt_q + CNT_W'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            in0_q     <= '0;
            in1_q     <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign pop = m_valid && m_ready;

    invk2j_res_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({core_out0, core_out1}),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level)
    );

    assign core_in0  = in0_q;
    assign core_in1  = in1_q;
    assign m_valid   = (fifo_level != '0);
    assign m_data    = fifo_dout;
    assign busy      = (state_q != ST_IDLE);
    assign res_count = res_cnt_q;

endmodule

// File: tb/tb_invk2j_stream_ctrl.sv
// Scoreboard bench for invk2j_stream_ctrl with a stub core (out0=in0+1, out1=~in1).
module tb_invk2j_stream_ctrl;

    localparam int DW     = 32;
    localparam int SETTLE = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, s_valid, s_ready, m_valid, m_ready, busy;
    logic [DW-1:0]    s_x, s_y, core_in0, core_in1, core_out0, core_out1;
    logic [2*DW-1:0]  m_data;
    logic [CNT_W-1:0] res_count;

    assign core_out0 = core_in0 + 32'd1;
    assign core_out1 = core_in1 ^ 32'hFFFF_FFFF;

    invk2j_stream_ctrl #(
        .DW(DW), .SETTLE(SETTLE), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .core_in0(core_in0), .core_in1(core_in1),
        .core_out0(core_out0), .core_out1(core_out1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .res_count(res_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pops  = 0;
    int rdy_mode = 0;           // 0: hold off, 1: always ready, 2: random
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return {x + 32'd1, ~y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out / unexpected", name);
    endtask

    // Monitor: pops the scoreboard on every consumer handshake, checks head stability.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_dat  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("head_stable", m_data, prev_dat);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else if (m_ready) begin
                    check("result", m_data, exp_q.pop_front());
                    pops++;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_dat  = m_data;
        end
    end

    // All tasks start and end at #1 after a posedge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, output int e_edge);
        s_x = x;
        s_y = y;
        s_valid = 1'b1;
        e_edge = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (s_ready && !rst) begin
                exp_q.push_back(model(x, y));
                e_edge = cyc + 1;
                break;
            end
        end
        if (e_edge < 0) fail_now("send_timeout");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!m_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("wait_empty");
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int seen;
        int pops_before;
        bit bad;
        logic [31:0] rx, ry;

        rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b0;

        // 1. Reset
        @(negedge clk);
        check("s_ready_in_reset", 64'(s_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_count", 64'(res_count), 64'd0);
        check("rst_core_in0", 64'(core_in0), 64'd0);
        check("rst_core_in1", 64'(core_in1), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // 2. Single pair with latency
        rdy_mode = 0;
        send(32'h0001_0000, 32'h0002_0000, e);
        @(negedge clk);
        check("core_in0_drive", 64'(core_in0), 64'h0001_0000);
        check("core_in1_drive", 64'(core_in1), 64'h0002_0000);
        check("busy_wait", 64'(busy), 64'd1);
        check("s_ready_busy", 64'(s_ready), 64'd0);
        seen = -1;
        for (int n = 0; n < 50; n++) begin
            if (m_valid) begin seen = cyc; break; end
            @(negedge clk);
        end
        if (seen < 0) fail_now("single_m_valid");
        else check("latency", 64'(seen - e), 64'(SETTLE + 1));
        check("single_m_data", m_data, 64'h0001_0001_FFFD_FFFF);
        check("single_res_count", 64'(res_count), 64'd1);
        check("core_in0_held", 64'(core_in0), 64'h0001_0000);
        @(posedge clk);
        #1 rdy_mode = 1;
        wait_empty();

        // 3. Backpressure on a full FIFO
        rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) send($urandom, $urandom, e);
        wait_idle();
        s_x = $urandom; s_y = $urandom; s_valid = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (s_ready) bad = 1'b1;
        end
        check("full_blocks_s_ready", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        pops_before = pops;
        rdy_mode = 1;
        send(s_x, s_y, e);
        check("accepted_after_pop", 64'(pops > pops_before), 64'd1);
        wait_idle();
        wait_empty();
        check("bp_res_count", 64'(res_count), 64'd6);

        // 4. Push and pop on the same edge
        rdy_mode = 0;
        rx = $urandom; ry = $urandom;
        send(rx, ry, e);
        wait_idle();
        rx = $urandom; ry = $urandom;
        send(rx, ry, e);
        for (int n = 0; n < 50 && cyc < e + SETTLE; n++) begin
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        @(posedge clk);
        #1 rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        check("simul_m_valid", 64'(m_valid), 64'd1);
        check("simul_head", m_data, model(rx, ry));
        check("simul_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rdy_mode = 1;
        wait_empty();
        check("simul_res_count", 64'(res_count), 64'd8);

        // 5. Reset mid-WAIT with two buffered results
        rdy_mode = 0;
        send($urandom, $urandom, e);
        send($urandom, $urandom, e);
        send($urandom, $urandom, e);
        @(negedge clk);
        check("mid_wait_busy", 64'(busy), 64'd1);
        check("mid_wait_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check("abort_m_valid", 64'(m_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res_count", 64'(res_count), 64'd0);
        check("abort_core_in0", 64'(core_in0), 64'd0);
        check("abort_core_in1", 64'(core_in1), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 6. Counter and pointer wrap under random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send($urandom, $urandom, e);
        end
        wait_idle();
        rdy_mode = 1;
        wait_empty();
        check("wrap_res_count", 64'(res_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
